// File: rtl/issue_queue_nxm.sv
// Out-of-order issue queue: compacting storage with the oldest entry in slot 0. Accepts up to NUM_IN
// micro-ops per cycle, wakes operands by tag broadcast and issues up to NUM_OUT ready entries, oldest first.
module issue_queue_nxm #(
    parameter int unsigned WIDTH_REG = 3,
    parameter int unsigned WIDTH_TAG = 3,
    parameter int unsigned WIDTH_BRM = 3,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned NUM_IN    = 4,
    parameter int unsigned NUM_OUT   = 2,
    parameter int unsigned NUM_WAKE  = 4,
    localparam int unsigned WIDTH    = 7 + WIDTH_BRM + WIDTH_TAG + 3 * WIDTH_REG + 3,
    localparam int unsigned OWIDTH   = WIDTH - 3
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_IN*WIDTH-1:0]       i_inst,
    input  logic                          i_en,
    output logic                          o_full,
    input  logic [NUM_WAKE*WIDTH_REG-1:0] i_wdest,
    input  logic [NUM_WAKE-1:0]           i_wvalid,
    input  logic [WIDTH_BRM-1:0]          i_BrKill,
    input  logic [NUM_OUT-1:0]            i_fu_ready,
    output logic [NUM_OUT*OWIDTH-1:0]     o_inst,
    output logic [NUM_OUT-1:0]            o_valid
);

    localparam int unsigned CW     = $clog2(DEPTH + 1);
    localparam int unsigned PR1_LO = 3;
    localparam int unsigned PR2_LO = 3 + WIDTH_REG;
    localparam int unsigned BRM_LO = 3 + 3 * WIDTH_REG + WIDTH_TAG;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;

    logic [DEPTH-1:0] occ, kill, rdy, issued;
    logic             accept;

    function automatic logic woken(input logic [WIDTH_REG-1:0] reg_tag);
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < NUM_WAKE; w++) begin
            if (i_wvalid[w] && i_wdest[w*WIDTH_REG +: WIDTH_REG] == reg_tag) hit = 1'b1;
        end
        return hit;
    endfunction

    assign o_full = count_q > CW'(DEPTH - NUM_IN);
    assign accept = i_en & ~o_full;

    always_comb begin
        occ  = '0;
        kill = '0;
        rdy  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ[i]  = CW'(i) < count_q;
            kill[i] = |(mem_q[i][BRM_LO +: WIDTH_BRM] & i_BrKill);
            rdy[i]  = occ[i] & ~kill[i] & mem_q[i][2] & mem_q[i][1] & mem_q[i][0];
        end
    end

    // The n-th ready slot (ascending) pairs with the n-th ready port (ascending).
    always_comb begin
        int unsigned slot_rank [DEPTH];
        int unsigned port_rank [NUM_OUT];
        int unsigned s;
        int unsigned p_cnt;
        o_valid = '0;
        o_inst  = '0;
        issued  = '0;
        s       = 0;
        p_cnt   = 0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_rank[i] = s;
            if (rdy[i]) s = s + 1;
        end
        for (int p = 0; p < NUM_OUT; p++) begin
            port_rank[p] = p_cnt;
            if (i_fu_ready[p]) p_cnt = p_cnt + 1;
        end
        for (int p = 0; p < NUM_OUT; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_fu_ready[p] && rdy[i] && slot_rank[i] == port_rank[p]) begin
                    o_valid[p]                  = 1'b1;
                    o_inst[p*OWIDTH +: OWIDTH] = mem_q[i][WIDTH-1:3];
                    issued[i]                   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        logic [WIDTH-1:0] ent;
        logic [CW-1:0]    wp;
        for (int j = 0; j < DEPTH; j++) mem_d[j] = '0;
        wp  = '0;
        ent = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occ[i] && !kill[i] && !issued[i]) begin
                ent    = mem_q[i];
                ent[0] = ent[0] | woken(ent[PR1_LO +: WIDTH_REG]);
                ent[1] = ent[1] | woken(ent[PR2_LO +: WIDTH_REG]);
                for (int j = 0; j < DEPTH; j++) begin
                    if (CW'(j) == wp) mem_d[j] = ent;
                end
                wp = wp + CW'(1);
            end
        end
        // Space was checked against the registered count, so appends always fit.
        for (int l = 0; l < NUM_IN; l++) begin
            ent = i_inst[l*WIDTH +: WIDTH];
            if (accept && ent[2] && !(|(ent[BRM_LO +: WIDTH_BRM] & i_BrKill))) begin
                ent[0] = ent[0] | woken(ent[PR1_LO +: WIDTH_REG]);
                ent[1] = ent[1] | woken(ent[PR2_LO +: WIDTH_REG]);
                for (int j = 0; j < DEPTH; j++) begin
                    if (CW'(j) == wp) mem_d[j] = ent;
                end
                wp = wp + CW'(1);
            end
        end
        count_d = wp;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

endmodule

// File: tb/tb_issue_queue_nxm.sv
// Directed bench for issue_queue_nxm: expected issued micro-ops go into a scoreboard queue at dispatch
// and are popped in port order whenever the queue presents a valid output.
module tb_issue_queue_nxm;

    localparam int WR = 3;
    localparam int WT = 3;
    localparam int WB = 3;
    localparam int NI = 4;
    localparam int NO = 2;
    localparam int NW = 4;
    localparam int W  = 7 + WB + WT + 3 * WR + 3;
    localparam int OW = W - 3;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [NI*W-1:0]   i_inst;
    logic              i_en;
    logic              o_full;
    logic [NW*WR-1:0]  i_wdest;
    logic [NW-1:0]     i_wvalid;
    logic [WB-1:0]     i_BrKill;
    logic [NO-1:0]     i_fu_ready;
    logic [NO*OW-1:0]  o_inst;
    logic [NO-1:0]     o_valid;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [OW-1:0] sbq [$];

    issue_queue_nxm dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_inst     (i_inst),
        .i_en       (i_en),
        .o_full     (o_full),
        .i_wdest    (i_wdest),
        .i_wvalid   (i_wvalid),
        .i_BrKill   (i_BrKill),
        .i_fu_ready (i_fu_ready),
        .o_inst     (o_inst),
        .o_valid    (o_valid)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1);
    end

    function automatic logic [W-1:0] mk(input logic [6:0] uop, input logic [2:0] brm,
                                        input logic [2:0] pr1, input logic p1, input logic p2);
        return {uop, brm, uop[2:0], ~uop[2:0], 3'b000, pr1, 1'b1, p2, p1};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_issue(input string tag);
        logic [OW-1:0] exp;
        for (int p = 0; p < NO; p++) begin
            if (o_valid[p]) begin
                if (sbq.size() == 0) begin
                    vectors++;
                    assert (sbq.size() != 0) else begin
                        miscompares++;
                        $error("FAIL %s port%0d: observed %h expected no issue", tag, p,
                               o_inst[p*OW +: OW]);
                    end
                end else begin
                    exp = sbq.pop_front();
                    chk(tag, 64'(o_inst[p*OW +: OW]), 64'(exp));
                end
            end else begin
                chk({tag, "_idle"}, 64'(o_inst[p*OW +: OW]), 64'd0);
            end
        end
    endtask

    task automatic push(input logic [W-1:0] e);
        sbq.push_back(e[W-1:3]);
    endtask

    task automatic set_lane(input int l, input logic [W-1:0] e);
        i_inst[l*W +: W] = e;
    endtask

    task automatic idle();
        i_en       = 1'b0;
        i_inst     = '0;
        i_wdest    = '0;
        i_wvalid   = '0;
        i_BrKill   = '0;
        i_fu_ready = '0;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] e, x, y, e0, e1, f, g, r1, r3, r5, z;

        // Reset state
        idle();
        i_rst = 1'b1;
        #2;
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_full", 64'(o_full), 64'd0);
        chk("rst_inst", 64'(o_inst), 64'd0);
        tick();
        i_rst = 1'b0;

        // Four ready lanes drain two per cycle, oldest first
        i_en = 1'b1;
        i_fu_ready = 2'b11;
        for (int l = 0; l < NI; l++) begin
            e = mk(7'(16 + l), 3'b000, 3'b000, 1'b1, 1'b1);
            set_lane(l, e);
            push(e);
        end
        #2;
        chk("t1_empty", 64'(o_valid), 64'd0);
        tick();
        idle();
        i_fu_ready = 2'b11;
        #2;
        chk("t1_c1_v", 64'(o_valid), 64'd3);
        chk_issue("t1_c1");
        tick();
        #2;
        chk("t1_c2_v", 64'(o_valid), 64'd3);
        chk_issue("t1_c2");
        tick();
        #2;
        chk("t1_c3_v", 64'(o_valid), 64'd0);
        chk("t1_c3_full", 64'(o_full), 64'd0);
        tick();

        // Fill to DEPTH, third dispatch refused while full
        idle();
        i_en = 1'b1;
        for (int l = 0; l < NI; l++) begin
            e = mk(7'(32 + l), 3'b000, 3'b000, 1'b1, 1'b1);
            set_lane(l, e);
            push(e);
        end
        #2;
        chk("t2_full0", 64'(o_full), 64'd0);
        tick();
        for (int l = 0; l < NI; l++) begin
            e = mk(7'(40 + l), 3'b000, 3'b000, 1'b1, 1'b1);
            set_lane(l, e);
            push(e);
        end
        #2;
        chk("t2_full4", 64'(o_full), 64'd0);
        tick();
        for (int l = 0; l < NI; l++) set_lane(l, mk(7'(48 + l), 3'b000, 3'b000, 1'b1, 1'b1));
        #2;
        chk("t2_full8", 64'(o_full), 64'd1);
        tick();
        idle();
        i_fu_ready = 2'b11;
        for (int c = 0; c < 4; c++) begin
            #2;
            chk("t2_drain_full", 64'(o_full), (c < 2) ? 64'd1 : 64'd0);
            chk("t2_drain_v", 64'(o_valid), 64'd3);
            chk_issue("t2_drain");
            tick();
        end
        #2;
        chk("t2_empty_v", 64'(o_valid), 64'd0);
        chk("t2_sb_empty", 64'(sbq.size()), 64'd0);
        tick();

        // Wakeup: not visible the same cycle; dispatch bypass catches the same broadcast
        idle();
        i_fu_ready = 2'b11;
        x = mk(7'd64, 3'b000, 3'b110, 1'b0, 1'b1);
        set_lane(0, x);
        i_en = 1'b1;
        #2;
        chk("t3_disp_v", 64'(o_valid), 64'd0);
        tick();
        idle();
        i_fu_ready = 2'b11;
        i_wdest[2*WR +: WR] = 3'b110;
        i_wvalid = 4'b0100;
        y = mk(7'd65, 3'b000, 3'b110, 1'b0, 1'b1);
        set_lane(0, y);
        i_en = 1'b1;
        push(x);
        push(y);
        #2;
        chk("t3_same_v", 64'(o_valid), 64'd0);
        tick();
        idle();
        i_fu_ready = 2'b11;
        #2;
        chk("t3_next_v", 64'(o_valid), 64'd3);
        chk_issue("t3_next");
        tick();
        #2;
        chk("t3_after_v", 64'(o_valid), 64'd0);
        tick();

        // Branch kill masks stored and incoming entries
        idle();
        e0 = mk(7'd80, 3'b010, 3'b000, 1'b1, 1'b1);
        e1 = mk(7'd81, 3'b001, 3'b000, 1'b1, 1'b1);
        set_lane(0, e0);
        set_lane(1, e1);
        i_en = 1'b1;
        #2;
        tick();
        idle();
        i_BrKill = 3'b010;
        i_fu_ready = 2'b01;
        f = mk(7'd82, 3'b010, 3'b000, 1'b1, 1'b1);
        g = mk(7'd83, 3'b000, 3'b000, 1'b1, 1'b1);
        set_lane(0, f);
        set_lane(1, g);
        i_en = 1'b1;
        push(e1);
        #2;
        chk("t4_kill_v", 64'(o_valid), 64'd1);
        chk_issue("t4_kill");
        tick();
        idle();
        i_fu_ready = 2'b11;
        push(g);
        #2;
        chk("t4_post_v", 64'(o_valid), 64'd1);
        chk_issue("t4_post");
        tick();
        #2;
        chk("t4_empty_v", 64'(o_valid), 64'd0);
        tick();

        // Ready in slots 1,3,5; only port 1 available
        idle();
        r1 = mk(7'd97, 3'b000, 3'b000, 1'b1, 1'b1);
        r3 = mk(7'd99, 3'b000, 3'b000, 1'b1, 1'b1);
        r5 = mk(7'd101, 3'b000, 3'b000, 1'b1, 1'b1);
        set_lane(0, mk(7'd96, 3'b000, 3'b111, 1'b0, 1'b1));
        set_lane(1, r1);
        set_lane(2, mk(7'd98, 3'b000, 3'b111, 1'b0, 1'b1));
        set_lane(3, r3);
        i_en = 1'b1;
        #2;
        tick();
        idle();
        set_lane(0, mk(7'd100, 3'b000, 3'b111, 1'b0, 1'b1));
        set_lane(1, r5);
        i_en = 1'b1;
        #2;
        tick();
        idle();
        i_fu_ready = 2'b10;
        push(r1);
        #2;
        chk("t5_port1_v", 64'(o_valid), 64'd2);
        chk_issue("t5_port1");
        tick();
        idle();
        i_fu_ready = 2'b01;
        push(r3);
        #2;
        chk("t5_compact_v", 64'(o_valid), 64'd1);
        chk_issue("t5_compact");
        tick();
        idle();
        set_lane(0, mk(7'd102, 3'b000, 3'b111, 1'b0, 1'b1));
        set_lane(1, mk(7'd103, 3'b000, 3'b111, 1'b0, 1'b1));
        i_en = 1'b1;
        #2;
        chk("t5_fill_v", 64'(o_valid), 64'd0);
        chk("t5_fill_full", 64'(o_full), 64'd0);
        tick();

        // Asynchronous reset with six entries held
        idle();
        i_fu_ready = 2'b11;
        push(r5);
        #2;
        chk("t6_pre_full", 64'(o_full), 64'd1);
        chk("t6_pre_v", 64'(o_valid), 64'd1);
        chk_issue("t6_pre");
        i_rst = 1'b1;
        #1;
        chk("t6_rst_v", 64'(o_valid), 64'd0);
        chk("t6_rst_full", 64'(o_full), 64'd0);
        chk("t6_rst_inst", 64'(o_inst), 64'd0);
        tick();
        i_rst = 1'b0;
        idle();
        z = mk(7'd110, 3'b000, 3'b000, 1'b1, 1'b1);
        set_lane(0, z);
        i_en = 1'b1;
        #2;
        chk("t6_disp_v", 64'(o_valid), 64'd0);
        tick();
        idle();
        i_fu_ready = 2'b01;
        push(z);
        #2;
        chk("t6_slot0_v", 64'(o_valid), 64'd1);
        chk_issue("t6_slot0");
        chk("t6_slot0_full", 64'(o_full), 64'd0);
        tick();
        #2;
        chk("t6_end_v", 64'(o_valid), 64'd0);
        chk("t6_sb_empty", 64'(sbq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
